instr_mem_ctrl: RTL and testbench
=================================

// Module: instr_mem_ctrl
// PURPOSE
//  Parametrised instruction memory for the RISC-V core's fetch stage.
//  - Self-clears on reset using a one-word-per-cycle sweep.
//  - Accepts program words through a load port.
//  - Serves byte-addressed fetches with one-cycle registered latency and fault detection.
//  - Replaces the fixed 64x32 combinational instruction store.
// PARAMETERS
//  DATA_W     32            instruction word width, bits
//  DEPTH      64            number of words; power of two, >=2
//  ADDR_W     32            fetch byte-address width
//  CLEAR_WORD 32'h00000013  fill value written by the clear sweep (RV32I NOP)
//  IDX_W      $clog2(DEPTH) localparam: word-index width
// PORTS
//  clk          in   1       clock; all state updates on rising edge
//  reset        in   1       synchronous, active-high reset
//  ld_en        in   1       write ld_data to word ld_addr this cycle
//  ld_addr      in   IDX_W   load word index
//  ld_data      in   DATA_W  load word
//  fetch_req    in   1       fetch request, single-cycle pulse per fetch
//  fetch_addr   in   ADDR_W  fetch byte address
//  fetch_valid  out  1       instr_out/fetch_err valid this cycle
//  instr_out    out  DATA_W  fetched instruction, registered
//  fetch_err    out  1       fetch faulted (misaligned or out of range)
//  busy         out  1       clear sweep in progress; requests ignored
// BEHAVIOUR
//  Reset (reset=1 at an edge):
//   - state<=CLEAR, clr_cnt<=0.
//   - fetch_valid<=0, fetch_err<=0, instr_out<=CLEAR_WORD.
//   - Memory contents are not touched at the reset edge itself.
//  FSM CLEAR:
//   - Each cycle writes CLEAR_WORD to mem[clr_cnt], then clr_cnt++.
//   - When clr_cnt==DEPTH-1 is written, next state is READY.
//   - busy = (state==CLEAR), combinational.
//   - The clear takes exactly DEPTH cycles after reset deasserts.
//   - ld_en and fetch_req are ignored; fetch_valid stays 0.
//  FSM READY:
//   - Remains in READY until reset; there is no other exit.
//  Load path:
//   - In READY, ld_en=1 writes mem[ld_addr]<=ld_data at the edge.
//   - No acknowledge signal; the write is always accepted.
//  Fetch path (READY only):
//   - idx = fetch_addr[IDX_W+1:2].
//   - err = (fetch_addr[1:0]!=0) | (fetch_addr[ADDR_W-1:IDX_W+2]!=0).
//   - Cycle after fetch_req=1: fetch_valid=1, fetch_err=err.
//   - instr_out = err ? CLEAR_WORD : mem[idx].
//   - Cycle after fetch_req=0: fetch_valid=0, instr_out holds its last value.
//   - Back-to-back requests give one result per cycle, in order.
//  Same-cycle load and fetch to the same word:
//   - Read-first: the fetch returns the old word.
//   - The new word is visible to the next fetch.
//  Reset mid-operation:
//   - A fetch in flight is dropped; fetch_valid is 0 in the cycle after reset.
//   - The clear sweep restarts from word 0.
//   - Any partially loaded program is lost.
//  Width rule: when ADDR_W == IDX_W+2, the out-of-range term is constant 0.
// TESTING
//  T1 reset 1 cycle, then idle
//     -> busy=1 for exactly 64 cycles, then 0.
//     -> A fetch of 0x00 after that returns 32'h00000013 with err=0.
//  T2 load idx 5 = 32'hDEADBEEF; fetch_req with addr 0x14
//     -> next cycle: valid=1, instr_out=32'hDEADBEEF, err=0.
//  T3 fetch addr 0x16 (misaligned)
//     -> valid=1, err=1, instr_out=32'h00000013.
//  T3 fetch addr 0x100 (index 64, out of range)
//     -> valid=1, err=1.
//  T4 same cycle: load idx 3 = 32'h11111111 and fetch 0x0C (old 32'h00000013)
//     -> returns 32'h00000013.
//     -> A following fetch of 0x0C returns 32'h11111111.
//  T5 reset pulse during back-to-back fetches, after loading idx 2
//     -> valid=0 the cycle after reset; busy=1 for 64 cycles.
//     -> Afterwards, fetch 0x08 returns 32'h00000013.
//  T6 fetch_req and ld_en driven while busy
//     -> no fetch_valid; memory not written.
//     -> A post-clear read of the targeted word returns CLEAR_WORD.

Source files
------------

// File: rtl/instr_mem_ctrl.sv
// Instruction memory for the fetch stage: clears itself after reset, then
// accepts program loads and serves byte-addressed fetches one cycle later.
module instr_mem_ctrl #(
  parameter int          DATA_W     = 32,
  parameter int          DEPTH      = 64,
  parameter int          ADDR_W     = 32,
  parameter logic [31:0] CLEAR_WORD = 32'h00000013,
  localparam int         IDX_W      = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ld_en,
  input  logic [IDX_W-1:0]  ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_valid,
  output logic [DATA_W-1:0] instr_out,
  output logic              fetch_err,
  output logic              busy
);

  // state | meaning
  // CLEAR | sweeping CLEAR_WORD into one word per cycle; loads/fetches ignored
  // READY | loads and fetches serviced; left only through reset
  typedef enum logic {CLEAR, READY} state_t;

  localparam logic [DATA_W-1:0] FILL = DATA_W'(CLEAR_WORD);

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   clr_cnt, clr_cnt_nxt;
  logic [DATA_W-1:0]  mem [DEPTH];
  logic [IDX_W-1:0]   idx;
  logic               range_err;
  logic               err;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= CLEAR;
      clr_cnt <= '0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    busy        = 1'b0;
    case (state)
      CLEAR: begin
        busy        = 1'b1;
        clr_cnt_nxt = clr_cnt + IDX_W'(1);
        if (clr_cnt == IDX_W'(DEPTH - 1)) state_nxt = READY;
      end
      READY: state_nxt = READY;
      default: state_nxt = CLEAR;
    endcase
  end

  // No reset term: contents are only changed by the sweep or by loads.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == CLEAR)
        mem[clr_cnt] <= FILL;
      else if (ld_en)
        mem[ld_addr] <= ld_data;
    end
  end

  assign idx = fetch_addr[IDX_W+1:2];

  generate
    if (ADDR_W > IDX_W + 2) begin : g_range
      assign range_err = |fetch_addr[ADDR_W-1:IDX_W+2];
    end else begin : g_no_range
      assign range_err = 1'b0;
    end
  endgenerate

  assign err = (fetch_addr[1:0] != 2'b00) | range_err;

  // Read-first: a same-cycle load to idx lands after this read samples mem.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_valid <= 1'b0;
      fetch_err   <= 1'b0;
      instr_out   <= FILL;
    end else if (state == READY && fetch_req) begin
      fetch_valid <= 1'b1;
      fetch_err   <= err;
      instr_out   <= err ? FILL : mem[idx];
    end else begin
      fetch_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_instr_mem_ctrl.sv
// Directed bench for instr_mem_ctrl with default parameters (64 x 32-bit).
module tb_instr_mem_ctrl;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        reset;
  logic        ld_en;
  logic [5:0]  ld_addr;
  logic [31:0] ld_data;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        fetch_valid;
  logic [31:0] instr_out;
  logic        fetch_err;
  logic        busy;

  int errors = 0;
  int checks = 0;

  instr_mem_ctrl dut (
    .clk(clk), .reset(reset), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_valid(fetch_valid),
    .instr_out(instr_out), .fetch_err(fetch_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts busy cycles (bounded); also flags any fetch_valid seen meanwhile.
  task automatic wait_clear(output int n, output int valid_seen);
    n = 0;
    valid_seen = 0;
    while (busy && n < 200) begin
      tick();
      n++;
      if (busy && fetch_valid) valid_seen++;
    end
  endtask

  task automatic fetch_one(input logic [31:0] a);
    fetch_req  = 1'b1;
    fetch_addr = a;
    tick();
    fetch_req  = 1'b0;
  endtask

  task automatic test_reset();
    int n, vs;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (busy !== 1'b1 || fetch_valid !== 1'b0 || fetch_err !== 1'b0 || instr_out !== NOP) begin
      errors++;
      $display("FAIL reset_state: busy=%b valid=%b err=%b instr=%h, want 1 0 0 %h",
               busy, fetch_valid, fetch_err, instr_out, NOP);
    end
    wait_clear(n, vs);
    checks++;
    if (n !== 64) begin
      errors++;
      $display("FAIL clear_len: busy cycles=%0d, want 64", n);
    end
    fetch_one(32'h0);
    checks++;
    if (fetch_valid !== 1'b1 || fetch_err !== 1'b0 || instr_out !== NOP) begin
      errors++;
      $display("FAIL fetch_after_clear: valid=%b err=%b instr=%h, want 1 0 %h",
               fetch_valid, fetch_err, instr_out, NOP);
    end
    tick();
    checks++;
    if (fetch_valid !== 1'b0 || instr_out !== NOP) begin
      errors++;
      $display("FAIL idle_hold: valid=%b instr=%h, want 0 %h", fetch_valid, instr_out, NOP);
    end
  endtask

  task automatic test_load();
    ld_en = 1'b1; ld_addr = 6'd5; ld_data = 32'hDEADBEEF;
    tick();
    ld_en = 1'b0;
    fetch_one(32'h14);
    checks++;
    if (fetch_valid !== 1'b1 || fetch_err !== 1'b0 || instr_out !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL load_fetch: valid=%b err=%b instr=%h, want 1 0 deadbeef",
               fetch_valid, fetch_err, instr_out);
    end
  endtask

  task automatic test_fault();
    logic [31:0] addrs [3] = '{32'h16, 32'h100, 32'hFC};
    logic        errs  [3] = '{1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      fetch_one(addrs[i]);
      checks++;
      if (fetch_valid !== 1'b1 || fetch_err !== errs[i] || instr_out !== NOP) begin
        errors++;
        $display("FAIL fault_%h: valid=%b err=%b instr=%h, want 1 %b %h",
                 addrs[i], fetch_valid, fetch_err, instr_out, errs[i], NOP);
      end
    end
  endtask

  task automatic test_read_first();
    ld_en = 1'b1; ld_addr = 6'd3; ld_data = 32'h11111111;
    fetch_one(32'h0C);
    ld_en = 1'b0;
    checks++;
    if (fetch_valid !== 1'b1 || instr_out !== NOP) begin
      errors++;
      $display("FAIL read_first_old: valid=%b instr=%h, want 1 %h", fetch_valid, instr_out, NOP);
    end
    fetch_one(32'h0C);
    checks++;
    if (fetch_valid !== 1'b1 || instr_out !== 32'h11111111) begin
      errors++;
      $display("FAIL read_first_new: valid=%b instr=%h, want 1 11111111", fetch_valid, instr_out);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] addrs [3] = '{32'h14, 32'h0C, 32'h00};
    logic [31:0] exp   [3] = '{32'hDEADBEEF, 32'h11111111, NOP};
    fetch_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      fetch_addr = addrs[i];
      tick();
      checks++;
      if (fetch_valid !== 1'b1 || fetch_err !== 1'b0 || instr_out !== exp[i]) begin
        errors++;
        $display("FAIL b2b_%0d: valid=%b err=%b instr=%h, want 1 0 %h",
                 i, fetch_valid, fetch_err, instr_out, exp[i]);
      end
    end
    fetch_req = 1'b0;
  endtask

  task automatic test_reset_mid();
    int n, vs;
    ld_en = 1'b1; ld_addr = 6'd2; ld_data = 32'hCAFEF00D;
    tick();
    ld_en = 1'b0;
    fetch_req = 1'b1; fetch_addr = 32'h08;
    tick();
    checks++;
    if (fetch_valid !== 1'b1 || instr_out !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL mid_pre: valid=%b instr=%h, want 1 cafef00d", fetch_valid, instr_out);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    fetch_req = 1'b0;
    checks++;
    if (fetch_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset: valid=%b busy=%b, want 0 1", fetch_valid, busy);
    end
    wait_clear(n, vs);
    checks++;
    if (n !== 64) begin
      errors++;
      $display("FAIL mid_clear_len: busy cycles=%0d, want 64", n);
    end
    fetch_one(32'h08);
    checks++;
    if (fetch_valid !== 1'b1 || instr_out !== NOP) begin
      errors++;
      $display("FAIL mid_lost_idx2: valid=%b instr=%h, want 1 %h", fetch_valid, instr_out, NOP);
    end
    fetch_one(32'h14);
    checks++;
    if (fetch_valid !== 1'b1 || instr_out !== NOP) begin
      errors++;
      $display("FAIL mid_lost_idx5: valid=%b instr=%h, want 1 %h", fetch_valid, instr_out, NOP);
    end
  endtask

  task automatic test_busy_ignore();
    int n, vs;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    fetch_req = 1'b1; fetch_addr = 32'h00;
    ld_en = 1'b1; ld_addr = 6'd0; ld_data = 32'hBAD0BAD0;
    wait_clear(n, vs);
    fetch_req = 1'b0;
    ld_en = 1'b0;
    checks++;
    if (vs !== 0 || n !== 64) begin
      errors++;
      $display("FAIL busy_ignore_valid: valid cycles=%0d busy=%0d, want 0 64", vs, n);
    end
    checks++;
    if (fetch_valid !== 1'b0) begin
      errors++;
      $display("FAIL busy_exit_valid: valid=%b, want 0", fetch_valid);
    end
    fetch_one(32'h00);
    checks++;
    if (fetch_valid !== 1'b1 || fetch_err !== 1'b0 || instr_out !== NOP) begin
      errors++;
      $display("FAIL busy_ignore_load: valid=%b err=%b instr=%h, want 1 0 %h",
               fetch_valid, fetch_err, instr_out, NOP);
    end
  endtask

  initial begin
    reset = 1'b0; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    fetch_req = 1'b0; fetch_addr = '0;
    #2;
    test_reset();
    test_load();
    test_fault();
    test_read_first();
    test_back_to_back();
    test_reset_mid();
    test_busy_ignore();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
